ophd_interrupt_sequencer: RTL and testbench

Multi-cycle interrupt acceptance sequencer sitting between the opcode-head decoder and the bus/PC units. At each instruction boundary it arbitrates a latched NMI against NUM_IRQ maskable request lines, issues the one-cycle head pulses (CNMI set, TNMI reset, HALT release, IFF evacuation/clear), then runs the acknowledge, PC push and vector phases for NMI and maskable modes 0/1/2. It replaces the single-cycle combinational NMI head decode with one sequenced block covering both interrupt classes.

---
 rtl/ophd_interrupt_sequencer_if.sv | 20 ++
 rtl/ophd_interrupt_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ophd_interrupt_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ophd_interrupt_sequencer_if.sv
// Bus port of the interrupt sequencer: push writes and IM2 table reads.
// Signals: bus_req/bus_we/bus_sel/table_addr (master out), bus_ready/bus_rdata (master in).
interface ophd_interrupt_sequencer_if;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_sel;
    logic [15:0] table_addr;
    logic        bus_ready;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_req, bus_we, bus_sel, table_addr,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_sel, table_addr,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/ophd_interrupt_sequencer.sv
// Interrupt acceptance sequencer: NMI vs maskable arbitration at instruction
// boundaries, head pulses, acknowledge, PC push, vector fetch and jump.
// Ports: CLK/RESET, nmi_in, int_req, iff1, ei_block, im_mode, i_reg, boundary,
// ack_data, bus (master), busy, p2_* head pulses, m1_dummy, int_ack, ack_id,
// pc_load/pc_out, opcode_inject/inject_op.
module ophd_interrupt_sequencer #(
    parameter int          NUM_IRQ  = 4,
    parameter int          ACK_WAIT = 2,
    parameter logic [15:0] NMI_VEC  = 16'h0066,
    parameter logic [15:0] IM1_VEC  = 16'h0038,
    localparam int         ID_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    nmi_in,
    input  logic [NUM_IRQ-1:0]      int_req,
    input  logic                    iff1,
    input  logic                    ei_block,
    input  logic [1:0]              im_mode,
    input  logic [7:0]              i_reg,
    input  logic                    boundary,
    input  logic [7:0]              ack_data,
    ophd_interrupt_sequencer_if.master bus,
    output logic                    busy,
    output logic                    p2_set_cnmi,
    output logic                    p2_reset_tnmi,
    output logic                    p2_evacuate_iff,
    output logic                    p2_reset_lhalt,
    output logic                    p2_reset_iff1,
    output logic                    p2_reset_iff2,
    output logic                    m1_dummy,
    output logic                    int_ack,
    output logic [ID_W-1:0]         ack_id,
    output logic                    pc_load,
    output logic [15:0]             pc_out,
    output logic                    opcode_inject,
    output logic [7:0]              inject_op
);

    typedef enum logic [3:0] {
        S_IDLE, S_HEAD, S_NMI_M1, S_ACK, S_PUSH_HI,
        S_PUSH_LO, S_VEC_LO, S_VEC_HI, S_JUMP
    } state_t;

    state_t          state, state_nx;
    logic            nmi_q, tnmi, is_nmi;
    logic [1:0]      mode;
    logic [3:0]      ack_cnt;
    logic [6:0]      vec;
    logic [7:0]      i_q, inject_q;
    logic [15:0]     pc_q;
    logic [ID_W-1:0] grant_id;
    logic            accept_nmi, accept_irq, ack_last;

    assign accept_nmi = (state == S_IDLE) && boundary && tnmi;
    assign accept_irq = (state == S_IDLE) && boundary && !tnmi
                        && iff1 && !ei_block && (|int_req);
    assign ack_last   = (ack_cnt == 4'(ACK_WAIT + 1));
    assign pc_out     = pc_q;

    // Lowest set index wins: scan from the top so index 0 overrides.
    always_comb begin
        grant_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (int_req[i]) grant_id = ID_W'(i);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        busy            = (state != S_IDLE);
        p2_set_cnmi     = 1'b0;
        p2_reset_tnmi   = 1'b0;
        p2_evacuate_iff = 1'b0;
        p2_reset_lhalt  = 1'b0;
        p2_reset_iff1   = 1'b0;
        p2_reset_iff2   = 1'b0;
        m1_dummy        = 1'b0;
        int_ack         = 1'b0;
        pc_load         = 1'b0;
        opcode_inject   = 1'b0;
        inject_op       = inject_q;
        bus.bus_req     = 1'b0;
        bus.bus_we      = 1'b0;
        bus.bus_sel     = 2'd0;
        bus.table_addr  = 16'h0000;
        unique case (state)
            S_IDLE: begin
                if (accept_nmi || accept_irq) state_nx = S_HEAD;
            end
            S_HEAD: begin
                p2_reset_lhalt = 1'b1;
                p2_reset_iff1  = 1'b1;
                if (is_nmi) begin
                    p2_set_cnmi     = 1'b1;
                    p2_reset_tnmi   = 1'b1;
                    p2_evacuate_iff = 1'b1;
                    state_nx        = S_NMI_M1;
                end else begin
                    p2_reset_iff2 = 1'b1;
                    state_nx      = S_ACK;
                end
            end
            S_NMI_M1: begin
                m1_dummy = 1'b1;
                state_nx = S_PUSH_HI;
            end
            S_ACK: begin
                int_ack = 1'b1;
                if (ack_last) begin
                    // IM0 hands the byte straight to the decoder; the
                    // injected instruction does its own push.
                    if (mode == 2'd0) begin
                        opcode_inject = 1'b1;
                        inject_op     = ack_data;
                        state_nx      = S_IDLE;
                    end else begin
                        state_nx = S_PUSH_HI;
                    end
                end
            end
            S_PUSH_HI: begin
                bus.bus_req = 1'b1;
                bus.bus_we  = 1'b1;
                bus.bus_sel = 2'd0;
                if (bus.bus_ready) state_nx = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                bus.bus_req = 1'b1;
                bus.bus_we  = 1'b1;
                bus.bus_sel = 2'd1;
                if (bus.bus_ready) begin
                    state_nx = (!is_nmi && mode == 2'd2) ? S_VEC_LO : S_JUMP;
                end
            end
            S_VEC_LO: begin
                bus.bus_req    = 1'b1;
                bus.bus_sel    = 2'd2;
                bus.table_addr = {i_q, vec, 1'b0};
                if (bus.bus_ready) state_nx = S_VEC_HI;
            end
            S_VEC_HI: begin
                bus.bus_req    = 1'b1;
                bus.bus_sel    = 2'd3;
                bus.table_addr = {i_q, vec, 1'b1};
                if (bus.bus_ready) state_nx = S_JUMP;
            end
            S_JUMP: begin
                pc_load  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            nmi_q    <= 1'b0;
            tnmi     <= 1'b0;
            is_nmi   <= 1'b0;
            mode     <= 2'd0;
            ack_id   <= '0;
            ack_cnt  <= 4'd0;
            vec      <= 7'd0;
            i_q      <= 8'h00;
            inject_q <= 8'h00;
            pc_q     <= 16'h0000;
        end else begin
            nmi_q <= nmi_in;
            // A fresh edge in the clearing cycle keeps the request pending.
            tnmi  <= (nmi_in && !nmi_q) || (tnmi && !p2_reset_tnmi);
            if (accept_nmi) is_nmi <= 1'b1;
            if (accept_irq) begin
                is_nmi <= 1'b0;
                ack_id <= grant_id;
                mode   <= (im_mode == 2'd3) ? 2'd0 : im_mode;
            end
            ack_cnt <= (state == S_ACK) ? ack_cnt + 4'd1 : 4'd0;
            if (state == S_ACK && ack_last) begin
                vec <= ack_data[7:1];
                if (mode == 2'd0) inject_q <= ack_data;
            end
            if (state == S_PUSH_LO && state_nx == S_VEC_LO) i_q <= i_reg;
            if (state == S_PUSH_LO && state_nx == S_JUMP) begin
                pc_q <= is_nmi ? NMI_VEC : IM1_VEC;
            end
            if (state == S_VEC_LO && bus.bus_ready) pc_q[7:0]  <= bus.bus_rdata;
            if (state == S_VEC_HI && bus.bus_ready) pc_q[15:8] <= bus.bus_rdata;
        end
    end

endmodule

// File: tb/tb_ophd_interrupt_sequencer.sv
// Self-checking bench for ophd_interrupt_sequencer: vector table with a
// scoreboard queue, plus a reset-during-push sequence.
module tb_ophd_interrupt_sequencer;
    localparam int W = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        nmi_in = 1'b0;
    logic [3:0]  int_req = 4'h0;
    logic        iff1 = 1'b0;
    logic        ei_block = 1'b0;
    logic [1:0]  im_mode = 2'd0;
    logic [7:0]  i_reg = 8'h00;
    logic        boundary = 1'b0;
    logic [7:0]  ack_data = 8'h00;
    logic        busy, p2_set_cnmi, p2_reset_tnmi, p2_evacuate_iff;
    logic        p2_reset_lhalt, p2_reset_iff1, p2_reset_iff2;
    logic        m1_dummy, int_ack, pc_load, opcode_inject;
    logic [1:0]  ack_id;
    logic [15:0] pc_out;
    logic [7:0]  inject_op;
    logic [7:0]  rd_lo = 8'h00, rd_hi = 8'h00;
    logic        hold_rdy = 1'b0, stall_en = 1'b0, rdy_rand = 1'b1;

    ophd_interrupt_sequencer_if bif ();

    ophd_interrupt_sequencer #(
        .NUM_IRQ(4), .ACK_WAIT(W), .NMI_VEC(16'h0066), .IM1_VEC(16'h0038)
    ) dut (
        .CLK(CLK), .RESET(RESET), .nmi_in(nmi_in), .int_req(int_req),
        .iff1(iff1), .ei_block(ei_block), .im_mode(im_mode), .i_reg(i_reg),
        .boundary(boundary), .ack_data(ack_data), .bus(bif),
        .busy(busy), .p2_set_cnmi(p2_set_cnmi), .p2_reset_tnmi(p2_reset_tnmi),
        .p2_evacuate_iff(p2_evacuate_iff), .p2_reset_lhalt(p2_reset_lhalt),
        .p2_reset_iff1(p2_reset_iff1), .p2_reset_iff2(p2_reset_iff2),
        .m1_dummy(m1_dummy), .int_ack(int_ack), .ack_id(ack_id),
        .pc_load(pc_load), .pc_out(pc_out), .opcode_inject(opcode_inject),
        .inject_op(inject_op)
    );

    always #5 CLK = ~CLK;

    assign bif.bus_ready = !hold_rdy && rdy_rand;
    assign bif.bus_rdata = (bif.bus_sel == 2'd3) ? rd_hi : rd_lo;

    always @(posedge CLK) begin
        #1;
        rdy_rand = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    typedef struct {
        logic        nmi_edge, nmi_mid;
        logic [3:0]  req;
        logic        iff1, ei;
        logic [1:0]  mode;
        logic [7:0]  ireg, ack, lo, hi;
        logic        accept, is_nmi;
        logic [1:0]  id;
        logic [15:0] pc;
        int          lat;
        logic [15:0] blog;
    } vec_t;

    vec_t tbl[12];
    vec_t sbq[$];
    vec_t e;

    int errors = 0, checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: accumulates one sequence's observations, scores on completion.
    int         cyc = 0, bnd_cyc = 0, stalls = 0, m1n = 0, ackn = 0;
    int         hn = 0, act = 0, nloads = 0;
    logic [5:0] head = 6'd0, hp;
    logic [15:0] blog = 16'h0;
    logic       pstall = 1'b0, im0;
    logic [1:0] psel = 2'd0;

    always @(negedge CLK) begin
        cyc++;
        hp = {p2_set_cnmi, p2_reset_tnmi, p2_evacuate_iff,
              p2_reset_lhalt, p2_reset_iff1, p2_reset_iff2};
        if (busy || hp != 6'd0) act++;
        if (boundary && !busy) begin
            bnd_cyc = cyc; stalls = 0; m1n = 0; ackn = 0;
            hn = 0; head = 6'd0; blog = 16'h0; pstall = 1'b0;
        end
        if (hp != 6'd0) begin head = head | hp; hn++; end
        if (m1_dummy) m1n++;
        if (int_ack) ackn++;
        if (bif.bus_req) begin
            if (pstall) chk("sel_stable", 32'(bif.bus_sel), 32'(psel));
            if (bif.bus_ready) begin
                blog = {blog[11:0], 1'b0, bif.bus_we, bif.bus_sel};
                if (!bif.bus_we && sbq.size() > 0)
                    chk("table_addr", 32'(bif.table_addr),
                        32'({sbq[0].ireg, sbq[0].ack[7:1], bif.bus_sel == 2'd3}));
            end else begin
                stalls++;
            end
            pstall = !bif.bus_ready;
            psel   = bif.bus_sel;
        end else begin
            pstall = 1'b0;
        end
        if (pc_load || opcode_inject) begin
            nloads++;
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: pc_load=%0b inject=%0b expected none",
                         pc_load, opcode_inject);
            end else begin
                e = sbq.pop_front();
                im0 = !e.is_nmi && (e.mode == 2'd0 || e.mode == 2'd3);
                chk("latency", cyc - bnd_cyc, e.lat + stalls);
                chk("pc_load_strobe", 32'(pc_load), 32'(!im0));
                chk("inject_strobe", 32'(opcode_inject), 32'(im0));
                if (im0) chk("inject_op", 32'(inject_op), 32'(e.pc[7:0]));
                else     chk("pc_out", 32'(pc_out), 32'(e.pc));
                chk("head_pulses", 32'(head), e.is_nmi ? 32'h3E : 32'h07);
                chk("head_cycles", hn, 1);
                chk("m1_dummy", m1n, e.is_nmi ? 1 : 0);
                chk("int_ack_cycles", ackn, e.is_nmi ? 0 : W + 2);
                chk("bus_log", 32'(blog), 32'(e.blog));
                if (!e.is_nmi) chk("ack_id", 32'(ack_id), 32'(e.id));
            end
        end
    end

    logic [1:0] last_id = 2'd0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input vec_t v);
        int a0, n;
        step();
        int_req = v.req; iff1 = v.iff1; ei_block = v.ei; im_mode = v.mode;
        i_reg = v.ireg; ack_data = v.ack; rd_lo = v.lo; rd_hi = v.hi;
        if (v.nmi_edge) begin nmi_in = 1'b1; step(); end
        a0 = act;
        if (v.accept) sbq.push_back(v);
        boundary = 1'b1;
        step();
        boundary = 1'b0;
        nmi_in = 1'b0;
        if (v.nmi_mid) begin
            step(); step();
            nmi_in = 1'b1;
            step();
            nmi_in = 1'b0;
        end
        if (v.accept) begin
            if (!v.is_nmi) last_id = v.id;
            n = 0;
            while (sbq.size() != 0 && n < 200) begin step(); n++; end
            chk("done_in_time", 32'(n < 200), 32'd1);
            sbq.delete();
            step();
            chk("idle_after", 32'(busy), 32'd0);
            chk("ack_id_hold", 32'(ack_id), 32'(last_id));
        end else begin
            repeat (6) step();
            chk("masked_no_activity", act - a0, 0);
        end
        int_req = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, a0, l0;
        //          edge mid  req    iff1 ei  mode  ireg   ack    lo     hi     acc  nmi  id    pc        lat blog
        tbl[0]  = '{1'b1,1'b0,4'h0,  1'b1,1'b0,2'd1,8'h00,8'h00,8'h00,8'h00,1'b1,1'b1,2'd0,16'h0066,5, 16'h0045};
        tbl[1]  = '{1'b0,1'b0,4'h6,  1'b1,1'b0,2'd2,8'h12,8'h35,8'hCD,8'hAB,1'b1,1'b0,2'd1,16'hABCD,10,16'h4523};
        tbl[2]  = '{1'b1,1'b0,4'h1,  1'b1,1'b0,2'd1,8'h00,8'h00,8'h00,8'h00,1'b1,1'b1,2'd0,16'h0066,5, 16'h0045};
        tbl[3]  = '{1'b0,1'b0,4'h1,  1'b0,1'b0,2'd1,8'h00,8'h00,8'h00,8'h00,1'b0,1'b0,2'd0,16'h0000,0, 16'h0000};
        tbl[4]  = '{1'b0,1'b0,4'h1,  1'b1,1'b0,2'd1,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0,2'd0,16'h0038,8, 16'h0045};
        tbl[5]  = '{1'b0,1'b0,4'hF,  1'b0,1'b0,2'd1,8'h00,8'h00,8'h00,8'h00,1'b0,1'b0,2'd0,16'h0000,0, 16'h0000};
        tbl[6]  = '{1'b0,1'b0,4'hF,  1'b1,1'b1,2'd1,8'h00,8'h00,8'h00,8'h00,1'b0,1'b0,2'd0,16'h0000,0, 16'h0000};
        tbl[7]  = '{1'b0,1'b0,4'h8,  1'b1,1'b0,2'd0,8'h00,8'hFF,8'h00,8'h00,1'b1,1'b0,2'd3,16'h00FF,5, 16'h0000};
        tbl[8]  = '{1'b0,1'b0,4'h4,  1'b1,1'b0,2'd3,8'h00,8'hC7,8'h00,8'h00,1'b1,1'b0,2'd2,16'h00C7,5, 16'h0000};
        tbl[9]  = '{1'b0,1'b1,4'h8,  1'b1,1'b0,2'd1,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0,2'd3,16'h0038,8, 16'h0045};
        tbl[10] = '{1'b0,1'b0,4'h0,  1'b1,1'b0,2'd1,8'h00,8'h00,8'h00,8'h00,1'b1,1'b1,2'd0,16'h0066,5, 16'h0045};
        tbl[11] = '{1'b0,1'b0,4'h2,  1'b1,1'b0,2'd2,8'h80,8'hFF,8'h11,8'h22,1'b1,1'b0,2'd1,16'h2211,10,16'h4523};

        repeat (2) @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus", 32'({bif.bus_req, bif.bus_we, bif.bus_sel}), 32'd0);
        chk("rst_pulses", 32'({p2_set_cnmi, p2_reset_tnmi, p2_evacuate_iff, p2_reset_lhalt,
                               p2_reset_iff1, p2_reset_iff2, m1_dummy, int_ack,
                               pc_load, opcode_inject}), 32'd0);
        chk("rst_ack_id", 32'(ack_id), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        chk("rst_inject_op", 32'(inject_op), 32'd0);
        chk("rst_table_addr", 32'(bif.table_addr), 32'd0);
        step();
        RESET = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            stall_en = (pass == 1);
            for (int i = 0; i < 12; i++) run(tbl[i]);
        end
        stall_en = 1'b0;

        // Reset while stalled in PUSH_LO with a second NMI pending.
        step();
        nmi_in = 1'b1;
        step();
        boundary = 1'b1;
        step();
        boundary = 1'b0;
        nmi_in = 1'b0;
        n = 0;
        while (!(bif.bus_req && bif.bus_sel == 2'd1) && n < 20) begin step(); n++; end
        hold_rdy = 1'b1;
        chk("reach_push_lo", 32'(n < 20), 32'd1);
        nmi_in = 1'b1;
        step();
        nmi_in = 1'b0;
        step();
        chk("stalled_push_lo", 32'({busy, bif.bus_req, bif.bus_sel}), 32'b1101);
        l0 = nloads;
        RESET = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_bus_req", 32'(bif.bus_req), 32'd0);
        step();
        RESET = 1'b0;
        hold_rdy = 1'b0;
        step();
        a0 = act;
        boundary = 1'b1;
        step();
        boundary = 1'b0;
        repeat (8) step();
        chk("tnmi_lost", act - a0, 0);
        chk("no_pc_load_after_rst", nloads - l0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
